gbt_frame_tx: RTL



---
 rtl/gbt_frame_defs_pkg.sv | 32 +++
 rtl/gbt_frame_tx.sv | 129 ++++++++++++
 2 files changed

// File: rtl/gbt_frame_defs_pkg.sv
// Shared frame-format definitions for the GBT return-link transmitter and its loopback checker.
package gbt_frame_defs;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned SEQ_W  = 8;
    localparam int unsigned CSUM_W = 12;
    localparam int unsigned GAP_W  = 4;
    localparam int unsigned CNT_W  = 8;

    localparam logic [3:0] HDR_TAG = 4'hA;
    localparam logic [3:0] HDR_SUB = 4'h5;
    localparam logic [3:0] TRL_TAG = 4'hE;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PAY  = 2'd1,
        ST_TRL  = 2'd2,
        ST_GAP  = 2'd3
    } tx_state_e;

    typedef struct packed {
        logic [3:0]       tag;
        logic [3:0]       sub;
        logic [SEQ_W-1:0] seq;
    } hdr_word_t;

    typedef struct packed {
        logic [3:0]        tag;
        logic [CSUM_W-1:0] csum;
    } trl_word_t;

endpackage

// File: rtl/gbt_frame_tx.sv
// Return-link frame transmitter: drains a 1-cycle-latency source FIFO into
// header / payload / checksum-trailer frames on the CLK40 domain.
module gbt_frame_tx
    import gbt_frame_defs::*;
#(
    parameter int unsigned FRAME_LEN = 16,
    parameter int unsigned GAP_CYC   = 2,
    parameter logic [15:0] IDLE_WORD = 16'h5555
) (
    input  logic              CLK40,
    input  logic              RST,
    input  logic              ENA,
    input  logic              SRC_RDY,
    input  logic              SRC_MT,
    input  logic [15:0]       SRC_DATA,
    output logic              SRC_RD_EN,
    output logic [15:0]       TX_DATA,
    output logic              TX_VLD,
    output logic              BUSY,
    output logic [SEQ_W-1:0]  SEQ
);

    localparam logic [CNT_W-1:0] LEN_CNT  = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);
    localparam logic [GAP_W-1:0] GAP_LD   = GAP_W'(GAP_CYC);

    tx_state_e          state;
    logic [CNT_W-1:0]   issued;
    logic [CNT_W-1:0]   rcvd;
    logic [DATA_W-1:0]  csum;
    logic [GAP_W-1:0]   gap_cnt;
    logic               rd_d1;
    logic               hold;
    logic               start;
    logic               rd_en;

    // hold keeps one settled IDLE cycle between frames before a new start
    assign start = ENA && SRC_RDY && !SRC_MT && !hold;

    always_comb begin
        rd_en = 1'b0;
        if (!RST) begin
            case (state)
                ST_IDLE: rd_en = start;
                ST_PAY:  rd_en = (issued < LEN_CNT) && !SRC_MT;
                default: rd_en = 1'b0;
            endcase
        end
    end

    assign SRC_RD_EN = rd_en;

    always_ff @(posedge CLK40) begin
        if (RST) begin
            state   <= ST_IDLE;
            issued  <= '0;
            rcvd    <= '0;
            csum    <= '0;
            gap_cnt <= '0;
            rd_d1   <= 1'b0;
            hold    <= 1'b0;
            TX_DATA <= IDLE_WORD;
            TX_VLD  <= 1'b0;
            BUSY    <= 1'b0;
            SEQ     <= '0;
        end else begin
            rd_d1 <= rd_en;
            case (state)
                ST_IDLE: begin
                    hold    <= 1'b0;
                    TX_DATA <= IDLE_WORD;
                    TX_VLD  <= 1'b0;
                    if (start) begin
                        TX_DATA <= hdr_word_t'{tag: HDR_TAG, sub: HDR_SUB, seq: SEQ};
                        TX_VLD  <= 1'b1;
                        issued  <= CNT_W'(1);
                        rcvd    <= '0;
                        csum    <= '0;
                        BUSY    <= 1'b1;
                        state   <= ST_PAY;
                    end
                end
                ST_PAY: begin
                    if (rd_en) begin
                        issued <= issued + CNT_W'(1);
                    end
                    if (rd_d1) begin
                        TX_DATA <= SRC_DATA;
                        TX_VLD  <= 1'b1;
                        csum    <= csum + SRC_DATA;
                        rcvd    <= rcvd + CNT_W'(1);
                        if (rcvd == LAST_CNT) begin
                            state <= ST_TRL;
                        end
                    end else begin
                        TX_DATA <= IDLE_WORD;
                        TX_VLD  <= 1'b0;
                    end
                end
                ST_TRL: begin
                    TX_DATA <= trl_word_t'{tag: TRL_TAG, csum: csum[CSUM_W-1:0]};
                    TX_VLD  <= 1'b1;
                    SEQ     <= SEQ + SEQ_W'(1);
                    gap_cnt <= GAP_LD;
                    if (GAP_CYC == 0) begin
                        hold  <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    TX_DATA <= IDLE_WORD;
                    TX_VLD  <= 1'b0;
                    if (gap_cnt <= GAP_W'(1)) begin
                        hold  <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
